// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light lamp interface: error codes, lamp
// state encoding and the default phase durations used by tlc_top.
package tlc_pkg;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ONEHOT   = 3'd1;
  localparam logic [2:0] ERR_CONFLICT = 3'd2;
  localparam logic [2:0] ERR_SEQ      = 3'd3;
  localparam logic [2:0] ERR_TIMING   = 3'd4;
  localparam logic [2:0] ERR_STARVE   = 3'd5;

  localparam int DEF_LVALUE = 2;
  localparam int DEF_SVALUE = 4;

  typedef enum logic [1:0] {
    L_RED = 2'd0,
    L_GRN = 2'd1,
    L_YEL = 2'd2,
    L_BAD = 2'd3
  } lamp_t;

  function automatic lamp_t encode_lamp(input logic g, input logic y, input logic r);
    case ({g, y, r})
      3'b100:  return L_GRN;
      3'b010:  return L_YEL;
      3'b001:  return L_RED;
      default: return L_BAD;
    endcase
  endfunction

endpackage

// File: rtl/tlc_road_checker.sv
// Per-road lamp checker: one-hot lamps, G->Y->R->G sequencing and minimum
// green/yellow durations. Error outputs are combinational on the current sample.
module tlc_road_checker
  import tlc_pkg::*;
#(
  parameter int LVALUE = DEF_LVALUE,
  parameter int SVALUE = DEF_SVALUE,
  parameter int CW     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic g,
  input  logic y,
  input  logic r,
  output logic onehot_err,
  output logic seq_err,
  output logic timing_err,
  output logic g2y
);

  lamp_t          cur;
  lamp_t          prev_q, prev_d;
  logic           valid_q, valid_d;
  logic [CW-1:0]  dur_q, dur_d;
  logic           both_ok;
  logic           legal;

  always_comb begin
    cur     = encode_lamp(g, y, r);
    prev_d  = cur;
    valid_d = 1'b1;
    // Duration is the number of consecutive samples in the current state.
    if (!valid_q || cur != prev_q) begin
      dur_d = CW'(1);
    end else if (dur_q == {CW{1'b1}}) begin
      dur_d = dur_q;
    end else begin
      dur_d = dur_q + CW'(1);
    end

    both_ok = valid_q && (cur != L_BAD) && (prev_q != L_BAD);
    case (prev_q)
      L_GRN:   legal = (cur == L_GRN) || (cur == L_YEL);
      L_YEL:   legal = (cur == L_YEL) || (cur == L_RED);
      L_RED:   legal = (cur == L_RED) || (cur == L_GRN);
      default: legal = 1'b1;
    endcase

    onehot_err = (cur == L_BAD);
    seq_err    = both_ok && !legal;
    g2y        = both_ok && (prev_q == L_GRN) && (cur == L_YEL);
    timing_err = (g2y && (dur_q < CW'(LVALUE))) ||
                 (both_ok && (prev_q == L_YEL) && (cur == L_RED) && (dur_q < CW'(SVALUE)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= L_RED;
      valid_q <= 1'b0;
      dur_q   <= '0;
    end else begin
      prev_q  <= prev_d;
      valid_q <= valid_d;
      dur_q   <= dur_d;
    end
  end

endmodule

// File: rtl/tlc_monitor.sv
// Lamp-interface monitor: flags the first protocol violation (sticky code),
// pulses on every violating cycle and counts legal highway G->Y transitions.
module tlc_monitor
  import tlc_pkg::*;
#(
  parameter int LVALUE   = DEF_LVALUE,
  parameter int SVALUE   = DEF_SVALUE,
  parameter int MAX_WAIT = 16,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hg,
  input  logic          hy,
  input  logic          hr,
  input  logic          fg,
  input  logic          fy,
  input  logic          fr,
  input  logic          detect,
  output logic          err,
  output logic [2:0]    err_code,
  output logic          err_pulse,
  output logic [CW-1:0] hw_cycles
);

  logic hw_onehot, hw_seq, hw_timing, hw_g2y;
  logic fm_onehot, fm_seq, fm_timing, farm_g2y_unused;

  tlc_road_checker #(.LVALUE(LVALUE), .SVALUE(SVALUE), .CW(CW)) u_hw (
    .clk(clk), .reset(reset), .g(hg), .y(hy), .r(hr),
    .onehot_err(hw_onehot), .seq_err(hw_seq), .timing_err(hw_timing), .g2y(hw_g2y)
  );

  tlc_road_checker #(.LVALUE(LVALUE), .SVALUE(SVALUE), .CW(CW)) u_farm (
    .clk(clk), .reset(reset), .g(fg), .y(fy), .r(fr),
    .onehot_err(fm_onehot), .seq_err(fm_seq), .timing_err(fm_timing), .g2y(farm_g2y_unused)
  );

  logic          err_q, err_d;
  logic [2:0]    code_q, code_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] hw_q, hw_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          starve_cond, starve_err, conflict_err, any_err;
  logic [2:0]    code_now;

  always_comb begin
    conflict_err = !hr && !fr;
    starve_cond  = detect && !fg;
    // Starvation fires on the sample that brings the count to MAX_WAIT and
    // every following sample while the condition persists.
    starve_err   = starve_cond && (wait_q >= CW'(MAX_WAIT - 1));
    if (!starve_cond) begin
      wait_d = '0;
    end else if (wait_q >= CW'(MAX_WAIT)) begin
      wait_d = CW'(MAX_WAIT);
    end else begin
      wait_d = wait_q + CW'(1);
    end

    if (hw_onehot || fm_onehot)      code_now = ERR_ONEHOT;
    else if (conflict_err)           code_now = ERR_CONFLICT;
    else if (hw_seq || fm_seq)       code_now = ERR_SEQ;
    else if (hw_timing || fm_timing) code_now = ERR_TIMING;
    else if (starve_err)             code_now = ERR_STARVE;
    else                             code_now = ERR_NONE;
    any_err = (code_now != ERR_NONE);

    err_d   = err_q || any_err;
    code_d  = err_q ? code_q : code_now;
    pulse_d = any_err;
    hw_d    = (hw_g2y && hw_q != {CW{1'b1}}) ? hw_q + CW'(1) : hw_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      pulse_q <= 1'b0;
      hw_q    <= '0;
      wait_q  <= '0;
    end else begin
      err_q   <= err_d;
      code_q  <= code_d;
      pulse_q <= pulse_d;
      hw_q    <= hw_d;
      wait_q  <= wait_d;
    end
  end

  assign err       = err_q;
  assign err_code  = code_q;
  assign err_pulse = pulse_q;
  assign hw_cycles = hw_q;

endmodule

// File: tb/tb_tlc_monitor.sv
// Directed bench for tlc_monitor: legal cycles, each violation class,
// priority, sticky code and asynchronous reset.
module tb_tlc_monitor;

  localparam int CW = 8;
  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  logic          clk = 1'b0;
  logic          reset;
  logic          hg, hy, hr, fg, fy, fr, detect;
  logic          err;
  logic [2:0]    err_code;
  logic          err_pulse;
  logic [CW-1:0] hw_cycles;

  int vectors = 0;
  int errors  = 0;

  tlc_monitor #(.LVALUE(2), .SVALUE(4), .MAX_WAIT(16), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .hg(hg), .hy(hy), .hr(hr), .fg(fg), .fy(fy), .fr(fr), .detect(detect),
    .err(err), .err_code(err_code), .err_pulse(err_pulse), .hw_cycles(hw_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic e_err, input logic [2:0] e_code,
                         input logic e_pulse);
    chk({tag, ".err"}, {7'd0, err}, {7'd0, e_err});
    chk({tag, ".code"}, {5'd0, err_code}, {5'd0, e_code});
    chk({tag, ".pulse"}, {7'd0, err_pulse}, {7'd0, e_pulse});
  endtask

  // Drive one sample just after an edge, then wait past the capturing edge.
  task automatic apply(input logic [2:0] h, input logic [2:0] f, input logic d);
    {hg, hy, hr} = h;
    {fg, fy, fr} = f;
    detect = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    chk_out(tag, 1'b0, 3'd0, 1'b0);
    chk({tag, ".hw"}, hw_cycles, 8'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    {hg, hy, hr} = G;
    {fg, fy, fr} = R;
    detect = 1'b0;
    #2;
    do_reset("rst0");

    // 1: three legal full cycles with detect during highway yellow
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 3; i++) begin apply(G, R, 1'b0); chk("t1.hg", {7'd0, err}, 8'd0); end
      for (int i = 0; i < 4; i++) begin apply(Y, R, 1'b1); chk("t1.hy", {7'd0, err}, 8'd0); end
      for (int i = 0; i < 3; i++) begin apply(R, G, 1'b0); chk("t1.fg", {7'd0, err}, 8'd0); end
      for (int i = 0; i < 4; i++) begin apply(R, Y, 1'b0); chk("t1.fy", {7'd0, err}, 8'd0); end
    end
    apply(G, R, 1'b0);
    chk_out("t1.end", 1'b0, 3'd0, 1'b0);
    chk("t1.hw", hw_cycles, 8'd3);

    // 2: multi-hot highway lamps for one cycle
    do_reset("rst2");
    apply(G, R, 1'b0);
    apply(G, R, 1'b0);
    apply(3'b101, R, 1'b0);
    chk_out("t2.bad", 1'b1, 3'd1, 1'b1);
    apply(G, R, 1'b0);
    chk_out("t2.after", 1'b1, 3'd1, 1'b0);

    // 3: green straight to red
    do_reset("rst3");
    for (int i = 0; i < 3; i++) apply(G, R, 1'b0);
    chk_out("t3.g", 1'b0, 3'd0, 1'b0);
    apply(R, R, 1'b0);
    chk_out("t3.seq", 1'b1, 3'd3, 1'b1);

    // 4a: yellow too short
    do_reset("rst4a");
    for (int i = 0; i < 2; i++) apply(G, R, 1'b0);
    for (int i = 0; i < 2; i++) apply(Y, R, 1'b0);
    chk_out("t4a.y", 1'b0, 3'd0, 1'b0);
    apply(R, R, 1'b0);
    chk_out("t4a.r", 1'b1, 3'd4, 1'b1);

    // 4b: yellow exactly minimum, green exactly minimum
    do_reset("rst4b");
    for (int i = 0; i < 2; i++) apply(G, R, 1'b0);
    for (int i = 0; i < 4; i++) apply(Y, R, 1'b0);
    apply(R, R, 1'b0);
    chk_out("t4b.r", 1'b0, 3'd0, 1'b0);
    chk("t4b.hw", hw_cycles, 8'd1);

    // 4c: green one cycle short; transition still counted
    do_reset("rst4c");
    apply(G, R, 1'b0);
    apply(Y, R, 1'b0);
    chk_out("t4c.y", 1'b1, 3'd4, 1'b1);
    chk("t4c.hw", hw_cycles, 8'd1);

    // 5a: starvation after 16 waiting samples, pulses while it persists
    do_reset("rst5a");
    for (int i = 0; i < 15; i++) apply(G, R, 1'b1);
    chk_out("t5a.15", 1'b0, 3'd0, 1'b0);
    apply(G, R, 1'b1);
    chk_out("t5a.16", 1'b1, 3'd5, 1'b1);
    apply(G, R, 1'b1);
    chk_out("t5a.17", 1'b1, 3'd5, 1'b1);
    apply(G, R, 1'b0);
    chk_out("t5a.drop", 1'b1, 3'd5, 1'b0);

    // 5b: detect dropped after 15 samples
    do_reset("rst5b");
    for (int i = 0; i < 15; i++) apply(G, R, 1'b1);
    apply(G, R, 1'b0);
    chk_out("t5b", 1'b0, 3'd0, 1'b0);

    // 6: both roads green, later error keeps code, reset mid-error
    do_reset("rst6");
    apply(G, R, 1'b0);
    apply(G, G, 1'b0);
    chk_out("t6.conf", 1'b1, 3'd2, 1'b1);
    apply(3'b110, R, 1'b0);
    chk_out("t6.sticky", 1'b1, 3'd2, 1'b1);
    do_reset("t6.rst");

    // 6b: onehot outranks simultaneous conflict
    apply(3'b110, G, 1'b0);
    chk_out("t6.prio", 1'b1, 3'd1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
